// File: rtl/fb_pkg.sv
// fb_pkg: shared geometry, FSM mode encoding and palette expansion for the
// framebuffer scan sequencer.
//   mode_t     sequencer state, value doubles as the mode readback code
//   pal3to24   {R,G,B} 1-bit-per-channel pixel -> 24-bit RGB
package fb_pkg;

   localparam int SRC_W      = 160;
   localparam int SRC_H      = 120;
   localparam int SCALE_LOG2 = 2;
   localparam int ACTIVE_W   = SRC_W << SCALE_LOG2;
   localparam int ACTIVE_H   = SRC_H << SCALE_LOG2;
   localparam int ADDR_W     = 15;
   localparam int COORD_W    = 10;

   typedef enum logic [1:0] {
      MENU      = 2'd0,
      PREP_GAME = 2'd1,
      GAME      = 2'd2,
      PREP_MENU = 2'd3
   } mode_t;

   function automatic logic [23:0] pal3to24(logic [2:0] px);
      return {{8{px[2]}}, {8{px[1]}}, {8{px[0]}}};
   endfunction

endpackage

// File: rtl/fb_scan_sequencer_if.sv
// fb_scan_sequencer_if: pixel-side bus of the scan sequencer.
//   cx, cy, game_req, menu_rgb, game_rgb   encoder/MCU/ROM/game -> sequencer
//   fb_addr, rom_ce, game_en, game_rst_n,
//   mode, rgb                              sequencer -> ROM/game/MCU/encoder
// master = environment driving the sequencer, slave = the sequencer itself.
interface fb_scan_sequencer_if;
   import fb_pkg::*;

   logic [COORD_W-1:0] cx;
   logic [COORD_W-1:0] cy;
   logic               game_req;
   logic [2:0]         menu_rgb;
   logic [2:0]         game_rgb;
   logic [ADDR_W-1:0]  fb_addr;
   logic               rom_ce;
   logic               game_en;
   logic               game_rst_n;
   logic [1:0]         mode;
   logic [23:0]        rgb;

   modport master (
      output cx, cy, game_req, menu_rgb, game_rgb,
      input  fb_addr, rom_ce, game_en, game_rst_n, mode, rgb
   );

   modport slave (
      input  cx, cy, game_req, menu_rgb, game_rgb,
      output fb_addr, rom_ce, game_en, game_rst_n, mode, rgb
   );

endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level.
//   clk    destination clock
//   rst_n  asynchronous active-low reset, both flops clear to 0
//   d      asynchronous input
//   q      synchronized output (two clk edges of latency)
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         q      <= 1'b0;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/fb_scan_sequencer.sv
// fb_scan_sequencer: video-side controller for the 160x120 3-bit framebuffer
// path upscaled 4x into a 640x480 HDMI encoder.
//   clk_pixel   pixel clock
//   sys_resetn  asynchronous active-low reset
//   bus         fb_scan_sequencer_if.slave: cx/cy scan position, game_req
//               from the MCU, menu/game pixel data in; ROM address/enable,
//               game engine enable/reset, mode readback, 24-bit pixel out
//
// state     | meaning
// MENU      | menu image shown, game engine held in reset
// PREP_GAME | game requested, waiting for frame boundary, engine still in reset
// GAME      | game pixels shown, engine running
// PREP_MENU | menu requested, waiting for frame boundary, game still shown
module fb_scan_sequencer
   import fb_pkg::*;
(
   input  logic                 clk_pixel,
   input  logic                 sys_resetn,
   fb_scan_sequencer_if.slave   bus
);

   logic               req_s;
   mode_t              state_q, state_d;
   logic               game_on_d;
   logic               game_en_q, game_rst_n_q, rom_ce_q;
   logic               active, frame_bnd;
   logic [COORD_W-1:0] src_x, src_y;
   logic [ADDR_W-1:0]  row_base, addr_d;
   logic [ADDR_W-1:0]  fb_addr_q;
   logic               act_d1, act_d2, sel_d1, sel_d2;
   logic [2:0]         px;
   logic [23:0]        rgb_q;

   sync_2ff u_req_sync (
      .clk   (clk_pixel),
      .rst_n (sys_resetn),
      .d     (bus.game_req),
      .q     (req_s)
   );

   assign active    = (bus.cx < COORD_W'(ACTIVE_W)) && (bus.cy < COORD_W'(ACTIVE_H));
   // First pixel of vertical blanking: switching here never tears a frame.
   assign frame_bnd = (bus.cx == '0) && (bus.cy == COORD_W'(ACTIVE_H));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         MENU:      if (req_s) state_d = PREP_GAME;
         PREP_GAME: if (!req_s) state_d = MENU;
                    else if (frame_bnd) state_d = GAME;
         GAME:      if (!req_s) state_d = PREP_MENU;
         PREP_MENU: if (req_s) state_d = GAME;
                    else if (frame_bnd) state_d = MENU;
         default:   state_d = MENU;
      endcase
   end

   // Outputs are registered from the next state so they line up with mode.
   assign game_on_d = (state_d == GAME) || (state_d == PREP_MENU);

   always_ff @(posedge clk_pixel or negedge sys_resetn) begin
      if (!sys_resetn) begin
         state_q      <= MENU;
         game_en_q    <= 1'b0;
         game_rst_n_q <= 1'b0;
         rom_ce_q     <= 1'b1;
      end else begin
         state_q      <= state_d;
         game_en_q    <= game_on_d;
         game_rst_n_q <= game_on_d;
         rom_ce_q     <= !game_on_d;
      end
   end

   // Row base = src_y * 160, done as src_y*128 + src_y*32.
   assign src_x    = bus.cx >> SCALE_LOG2;
   assign src_y    = bus.cy >> SCALE_LOG2;
   assign row_base = (ADDR_W'(src_y) << 7) + (ADDR_W'(src_y) << 5);
   assign addr_d   = row_base + ADDR_W'(src_x);

   always_ff @(posedge clk_pixel or negedge sys_resetn) begin
      if (!sys_resetn) begin
         fb_addr_q <= '0;
      end else if (active) begin
         fb_addr_q <= addr_d;
      end
   end

   // active/sel travel with the pixel so ROM data two cycles later is
   // matched to the source that was selected when it was addressed.
   assign px = sel_d2 ? bus.game_rgb : bus.menu_rgb;

   always_ff @(posedge clk_pixel or negedge sys_resetn) begin
      if (!sys_resetn) begin
         act_d1 <= 1'b0;
         act_d2 <= 1'b0;
         sel_d1 <= 1'b0;
         sel_d2 <= 1'b0;
         rgb_q  <= '0;
      end else begin
         act_d1 <= active;
         sel_d1 <= game_en_q;
         act_d2 <= act_d1;
         sel_d2 <= sel_d1;
         rgb_q  <= act_d2 ? pal3to24(px) : 24'h000000;
      end
   end

   assign bus.fb_addr    = fb_addr_q;
   assign bus.rom_ce     = rom_ce_q;
   assign bus.game_en    = game_en_q;
   assign bus.game_rst_n = game_rst_n_q;
   assign bus.mode       = state_q;
   assign bus.rgb        = rgb_q;

endmodule

// File: tb/tb_fb_scan_sequencer.sv
module tb_fb_scan_sequencer;

   logic clk_pixel = 1'b0;
   logic sys_resetn;

   fb_scan_sequencer_if bus ();

   fb_scan_sequencer dut (
      .clk_pixel  (clk_pixel),
      .sys_resetn (sys_resetn),
      .bus        (bus)
   );

   always #5 clk_pixel = ~clk_pixel;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: mode 0..3 (menu, going-to-game, game, going-to-menu),
   // pixel history as queues indexed by age.
   int m_mode;
   bit m_s1, m_s2;
   int m_addr;
   int m_rgb;
   bit act_q[$];
   bit sel_q[$];

   function automatic int expand(int p);
      int r = 0;
      for (int i = 0; i < 3; i++)
         if (((p >> i) & 1) != 0) r = r | (32'hFF << (8 * i));
      return r;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_s1 = 0; m_s2 = 0; m_addr = 0; m_rgb = 0;
      act_q = '{1'b0, 1'b0};
      sel_q = '{1'b0, 1'b0};
   endtask

   task automatic model_edge();
      int  x = int'(bus.cx);
      int  y = int'(bus.cy);
      bit  act = (x < 640) && (y < 480);
      bit  fbe = (x == 0) && (y == 480);
      bit  heading;
      act_q.push_back(act);
      sel_q.push_back(m_mode >= 2);
      // pixel addressed two cycles ago meets this cycle's source data
      m_rgb = act_q[0] ? expand(sel_q[0] ? int'(bus.game_rgb) : int'(bus.menu_rgb)) : 0;
      void'(act_q.pop_front());
      void'(sel_q.pop_front());
      if (act) m_addr = (y / 4) * 160 + x / 4;
      heading = (m_mode == 1) || (m_mode == 2);
      if (m_s2 != heading)
         m_mode = m_s2 ? ((m_mode == 3) ? 2 : 1) : ((m_mode == 1) ? 0 : 3);
      else if ((m_mode % 2 == 1) && fbe)
         m_mode = (m_mode == 1) ? 2 : 0;
      m_s2 = m_s1;
      m_s1 = bus.game_req;
   endtask

   task automatic compare_all();
      chk("mode",       32'(bus.mode),       32'(m_mode));
      chk("game_en",    32'(bus.game_en),    32'(m_mode >= 2));
      chk("game_rst_n", 32'(bus.game_rst_n), 32'(m_mode >= 2));
      chk("rom_ce",     32'(bus.rom_ce),     32'(m_mode < 2));
      chk("fb_addr",    32'(bus.fb_addr),    32'(m_addr));
      chk("rgb",        32'(bus.rgb),        32'(m_rgb));
   endtask

   task automatic tick();
      @(posedge clk_pixel);
      if (!sys_resetn) model_reset();
      else model_edge();
      #1;
      compare_all();
   endtask

   task automatic pxc(int x, int y, int menu, int game);
      bus.cx       = 10'(x);
      bus.cy       = 10'(y);
      bus.menu_rgb = 3'(menu);
      bus.game_rgb = 3'(game);
      tick();
   endtask

   task automatic px(int x, int y);
      pxc(x, y, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
   endtask

   task automatic rnd();
      int x = int'($urandom_range(0, 799));
      int y = int'($urandom_range(0, 524));
      if (x == 0 && y == 480) x = 1;
      px(x, y);
   endtask

   initial begin
      model_reset();
      sys_resetn   = 1'b0;
      bus.game_req = 1'b1;
      bus.cx       = 10'($urandom_range(0, 799));
      bus.cy       = 10'($urandom_range(0, 524));
      bus.menu_rgb = 3'($urandom_range(0, 7));
      bus.game_rgb = 3'($urandom_range(0, 7));

      // reset with random scan position and a pending game request
      repeat (4) rnd();
      chk("rst_mode",       32'(bus.mode),       32'd0);
      chk("rst_game_en",    32'(bus.game_en),    32'd0);
      chk("rst_game_rst_n", 32'(bus.game_rst_n), 32'd0);
      chk("rst_rom_ce",     32'(bus.rom_ce),     32'd1);
      chk("rst_rgb",        32'(bus.rgb),        32'd0);
      chk("rst_fb_addr",    32'(bus.fb_addr),    32'd0);

      bus.game_req = 1'b0;
      #4 sys_resetn = 1'b1;
      repeat (5) rnd();

      // address map
      px(4, 0);     chk("addr_4_0",     32'(bus.fb_addr), 32'd1);
      px(0, 4);     chk("addr_0_4",     32'(bus.fb_addr), 32'd160);
      px(639, 479); chk("addr_639_479", 32'(bus.fb_addr), 32'd19199);
      px(700, 10);  chk("addr_blank",   32'(bus.fb_addr), 32'd19199);
      rnd();
      rnd();
      chk("rgb_blank", 32'(bus.rgb), 32'd0);

      // palette in menu mode
      px(8, 8); rnd(); pxc(700, 10, 3'b110, int'($urandom_range(0, 7)));
      chk("pal_110", 32'(bus.rgb), 32'h00FFFF00);
      px(8, 8); rnd(); pxc(700, 10, 3'b001, int'($urandom_range(0, 7)));
      chk("pal_001", 32'(bus.rgb), 32'h000000FF);

      // switch to game at frame boundary
      bus.game_req = 1'b1;
      px(5, 100); px(6, 100); px(7, 100);
      chk("prep_game_mode",  32'(bus.mode),       32'd1);
      chk("prep_game_rst_n", 32'(bus.game_rst_n), 32'd0);
      for (int i = 0; i < 6; i++) px(i * 97, 100 + i * 50);
      px(0, 480);
      chk("game_mode",   32'(bus.mode),    32'd2);
      chk("game_en",     32'(bus.game_en), 32'd1);
      chk("game_rom_ce", 32'(bus.rom_ce),  32'd0);
      px(300, 500); px(799, 524);
      px(0, 0); rnd(); pxc(700, 10, 3'b010, 3'b101);
      chk("first_game_px", 32'(bus.rgb), 32'h00FF00FF);

      // back to menu
      bus.game_req = 1'b0;
      rnd(); rnd(); rnd();
      chk("prep_menu_mode", 32'(bus.mode),    32'd3);
      chk("prep_menu_en",   32'(bus.game_en), 32'd1);
      px(0, 480);
      chk("menu_mode",   32'(bus.mode),   32'd0);
      chk("menu_rom_ce", 32'(bus.rom_ce), 32'd1);

      // aborted request
      bus.game_req = 1'b1;
      for (int i = 0; i < 10; i++) px(i * 13, 200);
      chk("abort_prep", 32'(bus.mode), 32'd1);
      bus.game_req = 1'b0;
      px(300, 200); px(301, 200); px(302, 200);
      chk("abort_menu", 32'(bus.mode), 32'd0);
      px(0, 480);
      chk("abort_fb_en",   32'(bus.game_en), 32'd0);
      chk("abort_fb_mode", 32'(bus.mode),    32'd0);

      // reset while in game
      bus.game_req = 1'b1;
      rnd(); rnd(); rnd();
      px(0, 480);
      chk("pre_rst_game", 32'(bus.mode), 32'd2);
      px(10, 300); px(11, 300);
      #3 sys_resetn = 1'b0;
      #1;
      model_reset();
      chk("arst_mode",    32'(bus.mode),       32'd0);
      chk("arst_game_en", 32'(bus.game_en),    32'd0);
      chk("arst_rst_n",   32'(bus.game_rst_n), 32'd0);
      chk("arst_rgb",     32'(bus.rgb),        32'd0);
      repeat (3) rnd();
      #4 sys_resetn = 1'b1;
      rnd(); rnd(); rnd();
      chk("post_rst_prep", 32'(bus.mode), 32'd1);
      rnd();
      px(0, 480);
      chk("post_rst_game", 32'(bus.mode), 32'd2);

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 39) == 0) bus.game_req = ~bus.game_req;
         if ($urandom_range(0, 29) == 0) px(0, 480);
         else rnd();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
